// File: rtl/dff_bank_arbiter.sv
// Shared WIDTH-bit storage register written by N_REQ requesters under
// round-robin arbitration with a per-grant burst limit.
module dff_bank_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int WIDTH     = 8,
  parameter  int MAX_BURST = 2,
  localparam int OW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [OW-1:0]          owner,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar,
  output logic                   wr_done
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state, state_n;
  logic [OW-1:0]    ptr, ptr_n, owner_n, base, cand, pick;
  logic [BW-1:0]    burst_cnt, burst_n, burst_next;
  logic [N_REQ-1:0] gnt_n;
  logic [WIDTH-1:0] q_n, sel_data;
  logic             wr_done_n, write_en, release_now, rearb, found;

  // Explicit mux so unknowns on non-owner lanes cannot reach q.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == OW'(i)) sel_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  assign write_en    = (state == OWN) && req[owner];
  assign burst_next  = burst_cnt + 1'b1;
  assign release_now = (state == OWN) && (!req[owner] || (burst_next == BW'(MAX_BURST)));
  assign rearb       = (state == IDLE) || release_now;
  // A releasing owner becomes the pointer, so it is searched last.
  assign base        = release_now ? owner : ptr;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = base;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == OW'(N_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    owner_n   = owner;
    ptr_n     = ptr;
    burst_n   = burst_cnt;
    q_n       = q;
    wr_done_n = 1'b0;

    if (write_en) begin
      q_n       = sel_data;
      wr_done_n = 1'b1;
      burst_n   = burst_next;
    end

    if (release_now) begin
      ptr_n   = owner;
      burst_n = '0;
    end

    if (rearb) begin
      if (found) begin
        gnt_n       = '0;
        gnt_n[pick] = 1'b1;
        owner_n     = pick;
        state_n     = OWN;
      end else begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      ptr       <= OW'(N_REQ - 1);
      burst_cnt <= '0;
      q         <= '0;
      wr_done   <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      owner     <= owner_n;
      ptr       <= ptr_n;
      burst_cnt <= burst_n;
      q         <= q_n;
      wr_done   <= wr_done_n;
    end
  end

  assign q_bar = ~q;

endmodule
